// File: rtl/mul_accum_4bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mul_accum_4bit
//  Purpose  : Sums LEN 4-bit partial products into an ACC_W-bit result with a
//             sticky carry-out flag, using valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module mul_accum_4bit #(
    parameter int LEN   = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int               CNT_W    = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] C_LEN    = CNT_W'(LEN);
    localparam logic [1:0]       C_IDLE   = 2'd0;
    localparam logic [1:0]       C_ACCUM  = 2'd1;
    localparam logic [1:0]       C_DONE   = 2'd2;

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_beat;
    logic [ACC_W:0]   w_add;
    logic [CNT_W-1:0] w_cnt_nxt;

    // in_ready is purely a function of state, so a beat never needs in_valid
    // to feed back into the ready path.
    assign w_beat    = in_valid && (r_state != C_DONE);
    assign w_add     = {1'b0, r_acc} + {{(ACC_W-3){1'b0}}, in_p};
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= C_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE, C_ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= w_add[ACC_W-1:0];
                        r_ovf   <= r_ovf | w_add[ACC_W];
                        r_cnt   <= w_cnt_nxt;
                        r_state <= (w_cnt_nxt == C_LEN) ? C_DONE : C_ACCUM;
                    end
                end
                C_DONE: begin
                    if (out_ready) begin
                        r_state <= C_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state != C_DONE);
    assign out_valid = (r_state == C_DONE);
    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire
